// File: rtl/apb_i2c_controller.sv
// APB-programmable single-controller I2C engine.
// One CMD write runs START -> byte -> STOP (any subset) on open-drain SCL/SDA.
// Timing is built from quarter-bit slots of PRESCALE+1 PCLK cycles each.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no command running; lines hold their post-command level
// ST_START | (repeated) START condition, four quarters
// ST_BIT   | one of nine bit slots of a byte (eight data + ACK)
// ST_STOP  | STOP condition, four quarters
module apb_i2c_controller #(
  parameter logic [7:0] PRESCALE_RST = 8'd4,
  parameter int         ADDR_W       = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  input  logic              scl_in,
  output logic              scl_oe,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  q_q, q_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [3:0]  bit_q, bit_d;

  logic [7:0]  prescale_q, txdata_q, rxdata_q, rx_shift_q, tx_shift_q;
  logic        busy_q, rxnack_q, done_q;
  logic        c_stop_q, c_write_q, c_read_q, c_ack_q;
  logic        scl_hold_q, sda_hold_q;

  logic        wr_en, cmd_go, stall, sample, finish;
  logic        scl_c, sda_c;
  logic [2:0]  addr;
  state_t      first_phase;
  logic        unused_paddr;

  assign addr         = PADDR[2:0];
  assign unused_paddr = ^PADDR[ADDR_W-1:3];
  assign wr_en        = PSEL & PENABLE & PWRITE;
  // A command with no phase bits is accepted but does nothing.
  assign cmd_go       = wr_en && (addr == 3'd3) && !busy_q && (|PWDATA[3:0]);

  assign first_phase = PWDATA[0]               ? ST_START :
                       (PWDATA[2] | PWDATA[3]) ? ST_BIT   : ST_STOP;

  assign PREADY = 1'b1;
  assign scl_oe = scl_c;
  assign sda_oe = sda_c;
  assign irq    = done_q;

  // Register read mux; CMD and unmapped addresses read as zero.
  always_comb begin
    PRDATA = 8'h00;
    case (addr)
      3'd0:    PRDATA = prescale_q;
      3'd1:    PRDATA = txdata_q;
      3'd2:    PRDATA = rxdata_q;
      3'd4:    PRDATA = {5'd0, done_q, rxnack_q, busy_q};
      default: PRDATA = 8'h00;
    endcase
  end

  // FSM state, quarter index, quarter down-timer and bit index.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      q_q     <= 2'd0;
      tmr_q   <= 8'd0;
      bit_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
    end
  end

  // Line drive per state/quarter, stretch detection and phase sequencing.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    scl_c   = 1'b0;
    sda_c   = 1'b0;
    stall   = 1'b0;
    sample  = 1'b0;
    finish  = 1'b0;

    case (state_q)
      ST_START: begin
        scl_c = (q_q == 2'd3);
        sda_c = (q_q != 2'd0);
      end
      ST_BIT: begin
        scl_c = ~q_q[1];
        if (bit_q[3])
          sda_c = c_write_q ? 1'b0 : ~c_ack_q;
        else
          sda_c = c_write_q & ~tx_shift_q[~bit_q[2:0]];
      end
      ST_STOP: begin
        scl_c = (q_q == 2'd0);
        sda_c = ~q_q[1];
      end
      default: begin
        scl_c = scl_hold_q;
        sda_c = sda_hold_q;
      end
    endcase

    if (state_q == ST_IDLE) begin
      if (cmd_go) begin
        state_d = first_phase;
        q_d     = 2'd0;
        tmr_d   = prescale_q;
        bit_d   = 4'd0;
      end
    end else begin
      // A target holding SCL low freezes any quarter in which we release it.
      stall = ~scl_c & ~scl_in;
      if (!stall) begin
        if (tmr_q != 8'd0) begin
          tmr_d = tmr_q - 8'd1;
        end else begin
          tmr_d  = prescale_q;
          q_d    = q_q + 2'd1;
          sample = (state_q == ST_BIT) && (q_q == 2'd2);
          if (q_q == 2'd3) begin
            case (state_q)
              ST_START: begin
                if (c_write_q | c_read_q) state_d = ST_BIT;
                else if (c_stop_q)        state_d = ST_STOP;
                else begin
                  state_d = ST_IDLE;
                  finish  = 1'b1;
                end
              end
              ST_BIT: begin
                if (bit_q != 4'd8) begin
                  bit_d = bit_q + 4'd1;
                end else begin
                  bit_d = 4'd0;
                  if (c_stop_q) state_d = ST_STOP;
                  else begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                  end
                end
              end
              default: begin
                state_d = ST_IDLE;
                finish  = 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prescale_q <= PRESCALE_RST;
      txdata_q   <= 8'h00;
    end else begin
      if (wr_en && (addr == 3'd0) && !busy_q) prescale_q <= PWDATA;
      if (wr_en && (addr == 3'd1))            txdata_q   <= PWDATA;
    end
  end

  // Command latch, status flags, received data and idle line levels.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rxnack_q   <= 1'b0;
      rxdata_q   <= 8'h00;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      c_stop_q   <= 1'b0;
      c_write_q  <= 1'b0;
      c_read_q   <= 1'b0;
      c_ack_q    <= 1'b0;
      scl_hold_q <= 1'b0;
      sda_hold_q <= 1'b0;
    end else begin
      if (cmd_go) begin
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        c_stop_q   <= PWDATA[1];
        c_write_q  <= PWDATA[2];
        c_read_q   <= PWDATA[3];
        c_ack_q    <= PWDATA[4];
        tx_shift_q <= txdata_q;
      end
      if (finish) begin
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        // After START or a byte SCL stays low so the next command owns the bus.
        scl_hold_q <= (state_q != ST_STOP);
        sda_hold_q <= sda_c;
      end
      if (sample) begin
        if (c_write_q) begin
          if (bit_q[3]) rxnack_q <= sda_in;
        end else if (!bit_q[3]) begin
          rx_shift_q <= {rx_shift_q[6:0], sda_in};
          if (bit_q[2:0] == 3'd7) rxdata_q <= {rx_shift_q[6:0], sda_in};
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_i2c_controller.sv
// Directed bench for apb_i2c_controller with a small I2C target model.
module tb_apb_i2c_controller;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       scl_in, scl_oe, sda_in, sda_oe, irq;

  // Target model controls (written by the stimulus block only).
  int         tgt_mode = 0;      // 0 silent, 1 ACK a write, 2 return tgt_data
  logic [7:0] tgt_data = 8'h00;
  bit         stretch_arm = 1'b0;
  int         clear_req = 0;
  bit         meas_arm = 1'b0;

  // Target model state (written by the model block only).
  logic       tgt_scl_low = 1'b0, tgt_sda_low = 1'b0;
  int         clear_ack = 0;
  int         rise_cnt = 0, start_cnt = 0, stop_cnt = 0, stretch_cnt = 0;
  logic [7:0] cap_byte = 8'h00;
  logic       cap_ack = 1'b0;
  bit         in_low = 1'b0, stretched = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_now, sda_now;

  int         busy_cycles = 0;
  int         checks = 0, errors = 0;
  int         b0, cyc;
  logic [7:0] rd;

  assign scl_in = ~scl_oe & ~tgt_scl_low;
  assign sda_in = ~sda_oe & ~tgt_sda_low;

  apb_i2c_controller dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .scl_in(scl_in), .scl_oe(scl_oe), .sda_in(sda_in),
    .sda_oe(sda_oe), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic drive_low(input int idx);
    if (tgt_mode == 1) return (idx == 8);
    if (tgt_mode == 2) return (idx < 8) ? ~tgt_data[7-idx] : 1'b0;
    return 1'b0;
  endfunction

  // Target model: watches the wired lines between clock edges.
  always @(negedge PCLK) begin
    if (clear_req != clear_ack) begin
      clear_ack   = clear_req;
      rise_cnt    = 0;
      start_cnt   = 0;
      stop_cnt    = 0;
      cap_byte    = 8'h00;
      cap_ack     = 1'b0;
      stretched   = 1'b0;
      stretch_cnt = 0;
      tgt_scl_low = 1'b0;
      in_low      = ~prev_scl;
      tgt_sda_low = drive_low(0);
    end
    if (stretch_cnt > 0) begin
      stretch_cnt = stretch_cnt - 1;
      if (stretch_cnt == 0) tgt_scl_low = 1'b0;
    end else if (stretch_arm && !stretched && rise_cnt == 3 && in_low && !scl_oe) begin
      tgt_scl_low = 1'b1;
      stretch_cnt = 10;
      stretched   = 1'b1;
    end
    scl_now = ~scl_oe & ~tgt_scl_low;
    sda_now = ~sda_oe & ~tgt_sda_low;
    if (scl_now && prev_scl && prev_sda && !sda_now) start_cnt = start_cnt + 1;
    if (scl_now && prev_scl && !prev_sda && sda_now) stop_cnt = stop_cnt + 1;
    if (scl_now && !prev_scl) begin
      if (rise_cnt < 8) cap_byte = {cap_byte[6:0], sda_now};
      else if (rise_cnt == 8) cap_ack = sda_now;
      rise_cnt = rise_cnt + 1;
      in_low   = 1'b0;
    end else if (!scl_now && prev_scl) begin
      in_low      = 1'b1;
      tgt_sda_low = drive_low(rise_cnt);
      sda_now     = ~sda_oe & ~tgt_sda_low;
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  // Counts PCLK cycles with irq low while a command is being timed.
  always @(negedge PCLK) begin
    if (meas_arm && irq === 1'b0) busy_cycles = busy_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic tgt_setup(input int mode, input logic [7:0] data, input bit stretch);
    tgt_mode    = mode;
    tgt_data    = data;
    stretch_arm = stretch;
    clear_req   = clear_req + 1;
    @(negedge PCLK);
    #1;
  endtask

  task automatic issue(input logic [7:0] cmd);
    apb_write(5'd3, cmd);
    b0       = busy_cycles;
    meas_arm = 1'b1;
  endtask

  task automatic wait_done(output int n);
    int guard;
    guard = 0;
    while (irq !== 1'b1 && guard < 3000) begin
      @(posedge PCLK);
      #1;
      guard = guard + 1;
    end
    chk("done_timeout", 32'(irq), 32'h1);
    meas_arm = 1'b0;
    n = busy_cycles - b0;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 5'd0; PWDATA = 8'h00;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Reset state
    apb_read(5'd0, rd);  chk("rst_prescale", 32'(rd), 32'h04);
    apb_read(5'd4, rd);  chk("rst_status", 32'(rd), 32'h00);
    chk("rst_scl_oe", 32'(scl_oe), 32'h0);
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // START + WRITE 0xA5 + STOP, target ACKs, Q = 1
    apb_write(5'd0, 8'h00);
    apb_write(5'd1, 8'hA5);
    tgt_setup(1, 8'h00, 1'b0);
    issue(8'h07);
    wait_done(cyc);
    chk("wr_busy_cycles", 32'(cyc), 32'd44);
    chk("wr_byte_on_bus", 32'(cap_byte), 32'hA5);
    chk("wr_ack_bit", 32'(cap_ack), 32'h0);
    chk("wr_start_seen", 32'(start_cnt), 32'd1);
    chk("wr_stop_seen", 32'(stop_cnt), 32'd1);
    apb_read(5'd4, rd);  chk("wr_status", 32'(rd), 32'h04);
    chk("wr_irq", 32'(irq), 32'h1);
    chk("wr_lines_released", 32'({scl_oe, sda_oe}), 32'h0);

    // WRITE only, nobody answers
    tgt_setup(0, 8'h00, 1'b0);
    issue(8'h04);
    wait_done(cyc);
    chk("nack_busy_cycles", 32'(cyc), 32'd36);
    chk("nack_byte_on_bus", 32'(cap_byte), 32'hA5);
    apb_read(5'd4, rd);  chk("nack_status", 32'(rd), 32'h06);

    // READ + STOP with NACK, target returns 0x3C
    tgt_setup(2, 8'h3C, 1'b0);
    issue(8'h1A);
    wait_done(cyc);
    chk("rd_busy_cycles", 32'(cyc), 32'd40);
    apb_read(5'd2, rd);  chk("rd_rxdata", 32'(rd), 32'h3C);
    chk("rd_ninth_bit_high", 32'(cap_ack), 32'h1);
    chk("rd_stop_seen", 32'(stop_cnt), 32'd1);

    // WRITE 0x5A with a 10-cycle stretch during bit 3
    apb_write(5'd1, 8'h5A);
    tgt_setup(1, 8'h00, 1'b1);
    issue(8'h04);
    wait_done(cyc);
    chk("str_busy_cycles", 32'(cyc), 32'd46);
    chk("str_byte_on_bus", 32'(cap_byte), 32'h5A);
    apb_read(5'd4, rd);  chk("str_status", 32'(rd), 32'h04);

    // Q = 2; CMD, PRESCALE and TXDATA writes while busy
    apb_write(5'd0, 8'h01);
    apb_write(5'd1, 8'h81);
    tgt_setup(1, 8'h00, 1'b0);
    issue(8'h04);
    apb_write(5'd3, 8'h01);
    apb_write(5'd0, 8'h07);
    apb_write(5'd1, 8'h00);
    wait_done(cyc);
    chk("busy_wr_cycles", 32'(cyc), 32'd72);
    chk("busy_wr_byte", 32'(cap_byte), 32'h81);
    apb_read(5'd0, rd);  chk("busy_prescale_kept", 32'(rd), 32'h01);
    apb_read(5'd1, rd);  chk("busy_txdata_taken", 32'(rd), 32'h00);
    apb_read(5'd4, rd);  chk("busy_status", 32'(rd), 32'h04);
    apb_read(5'd3, rd);  chk("cmd_reads_zero", 32'(rd), 32'h00);

    // Reset in the middle of a byte
    tgt_setup(0, 8'h00, 1'b0);
    issue(8'h04);
    meas_arm = 1'b0;
    repeat (10) @(posedge PCLK);
    apb_read(5'd4, rd);  chk("mid_status_busy", 32'(rd), 32'h01);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_scl_oe", 32'(scl_oe), 32'h0);
    chk("mid_rst_sda_oe", 32'(sda_oe), 32'h0);
    PADDR = 5'd4;
    #1;
    chk("mid_rst_status", 32'(PRDATA), 32'h00);
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_read(5'd0, rd);  chk("mid_rst_prescale", 32'(rd), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
